bus_ad_responder: RTL and testbench

//  Device-side responder for the 8-bit multiplexed address/data bus (AD + CS_n, A_D, WR_n, RD_n).

---
 rtl/bus_ad_responder.sv | 210 +++++++++++++++++++++
 tb/tb_bus_ad_responder.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_ad_responder.sv
// bus_ad_responder
//   Device-side responder for an 8-bit multiplexed address/data bus.
//   The bus inputs are synchronised, the write strobe edges are decoded,
//   the address is latched, and a register file is kept. Read data goes back
//   through ad_out/ad_oe to the pad tri-state. Local logic gets a separate
//   read/write port into the same register file.
// Parameters
//   NREG         number of 8-bit registers, addresses 0..NREG-1 (NREG <= 256)
//   SYNC_FF      synchroniser depth on every bus input (>= 2)
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   cs_n, a_d, wr_n, rd_n        bus strobes (a_d: 0 = address, 1 = data)
//   ad_in                        AD value seen at the pad
//   ad_out, ad_oe                read data and pad drive enable
//   loc_addr, loc_wdata, loc_we  local write port (writes on the next clk)
//   loc_rdata                    combinational local read, 0x00 if out of range
//   bus_wr_pulse, bus_wr_addr    one-clk pulse and address of each committed bus data write
module bus_ad_responder #(
   parameter int unsigned NREG    = 16,
   parameter int unsigned SYNC_FF = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cs_n,
   input  logic       a_d,
   input  logic       wr_n,
   input  logic       rd_n,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   input  logic [7:0] loc_addr,
   input  logic [7:0] loc_wdata,
   input  logic       loc_we,
   output logic [7:0] loc_rdata,
   output logic       bus_wr_pulse,
   output logic [7:0] bus_wr_addr
);

   typedef enum logic {
      ST_IDLE,
      ST_RD_DRIVE
   } state_t;

   // Synchroniser word: {cs_n, a_d, wr_n, rd_n, ad[7:0]}; idle = cs_n/wr_n/rd_n high.
   localparam logic [11:0] IDLE_LVL = 12'hB00;

   logic [11:0] r_sync [SYNC_FF];
   logic        r_wr_d;
   logic        r_err;
   logic [7:0]  r_addr;
   logic [7:0]  r_regs [NREG];
   state_t      r_state;
   logic [7:0]  r_ad_out;
   logic        r_oe;
   logic        r_wr_pulse;
   logic [7:0]  r_wr_addr;

   logic        w_cs_n;
   logic        w_a_d;
   logic        w_wr_n;
   logic        w_rd_n;
   logic [7:0]  w_ad;
   logic        w_wr_n_pre;
   logic        w_addr_ok;
   logic        w_wr_rise;
   logic        w_wr_commit;
   logic        w_addr_wr;
   logic        w_data_wr;
   logic        w_rd_req;
   logic [7:0]  w_rd_sel;
   logic [7:0]  w_loc_sel;
   state_t      w_state_nxt;
   logic        w_load;
   logic        w_oe_nxt;

   // ---------------- input synchroniser ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < SYNC_FF; i++) begin
            r_sync[i] <= IDLE_LVL;
         end
      end else begin
         r_sync[0] <= {cs_n, a_d, wr_n, rd_n, ad_in};
         for (int unsigned i = 1; i < SYNC_FF; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   assign w_cs_n     = r_sync[SYNC_FF-1][11];
   assign w_a_d      = r_sync[SYNC_FF-1][10];
   assign w_wr_n     = r_sync[SYNC_FF-1][9];
   assign w_rd_n     = r_sync[SYNC_FF-1][8];
   assign w_ad       = r_sync[SYNC_FF-1][7:0];
   // wr_n one stage earlier: lets the registered ad_oe drop before the
   // fully synchronised wr_n goes low.
   assign w_wr_n_pre = r_sync[SYNC_FF-2][9];

   // ---------------- write strobe decode ----------------
   assign w_addr_ok   = ({1'b0, r_addr} < 9'(NREG));
   assign w_wr_rise   = w_wr_n & ~r_wr_d;
   // r_err remembers rd_n overlapping the wr_n low period (bus error).
   assign w_wr_commit = w_wr_rise & ~w_cs_n & w_rd_n & ~r_err;
   assign w_addr_wr   = w_wr_commit & ~w_a_d;
   assign w_data_wr   = w_wr_commit & w_a_d & w_addr_ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_d     <= 1'b1;
         r_err      <= 1'b0;
         r_addr     <= '0;
         r_wr_pulse <= 1'b0;
         r_wr_addr  <= '0;
      end else begin
         r_wr_d     <= w_wr_n;
         if (w_wr_n) begin
            r_err <= 1'b0;
         end else if (!w_rd_n) begin
            r_err <= 1'b1;
         end
         if (w_addr_wr) begin
            r_addr <= w_ad;
         end
         r_wr_pulse <= w_data_wr;
         if (w_data_wr) begin
            r_wr_addr <= r_addr;
         end
      end
   end

   // ---------------- register file ----------------
   // Bus write has priority when both ports target the same register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NREG; i++) begin
            if (w_data_wr && (r_addr == 8'(i))) begin
               r_regs[i] <= w_ad;
            end else if (loc_we && (loc_addr == 8'(i))) begin
               r_regs[i] <= loc_wdata;
            end
         end
      end
   end

   // Read muxes; addresses with no matching register yield 0x00.
   always_comb begin
      w_rd_sel  = '0;
      w_loc_sel = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (r_addr == 8'(i)) begin
            w_rd_sel = r_regs[i];
         end
         if (loc_addr == 8'(i)) begin
            w_loc_sel = r_regs[i];
         end
      end
   end

   assign loc_rdata = w_loc_sel;

   // ---------------- read FSM ----------------
   assign w_rd_req = ~w_cs_n & ~w_rd_n & w_a_d & w_wr_n & w_wr_n_pre;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_oe     <= 1'b0;
         r_ad_out <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_oe    <= w_oe_nxt;
         if (w_load) begin
            r_ad_out <= w_rd_sel;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_oe_nxt    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rd_req) begin
               w_state_nxt = ST_RD_DRIVE;
               w_load      = 1'b1;
               w_oe_nxt    = 1'b1;
            end
         end
         ST_RD_DRIVE: begin
            if (w_rd_req) begin
               w_oe_nxt = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign ad_out       = r_ad_out;
   assign ad_oe        = r_oe;
   assign bus_wr_pulse = r_wr_pulse;
   assign bus_wr_addr  = r_wr_addr;

endmodule

// File: tb/tb_bus_ad_responder.sv
// tb_bus_ad_responder
//   Directed bench for bus_ad_responder (NREG=16, SYNC_FF=2). Inputs change
//   1 time unit after a rising clk edge; outputs are sampled at the same point.
module tb_bus_ad_responder;

   logic       clk;
   logic       reset_n;
   logic       cs_n;
   logic       a_d;
   logic       wr_n;
   logic       rd_n;
   logic [7:0] ad_in;
   logic [7:0] ad_out;
   logic       ad_oe;
   logic [7:0] loc_addr;
   logic [7:0] loc_wdata;
   logic       loc_we;
   logic [7:0] loc_rdata;
   logic       bus_wr_pulse;
   logic [7:0] bus_wr_addr;

   int checks;
   int errors;

   bus_ad_responder #(
      .NREG    (16),
      .SYNC_FF (2)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cs_n         (cs_n),
      .a_d          (a_d),
      .wr_n         (wr_n),
      .rd_n         (rd_n),
      .ad_in        (ad_in),
      .ad_out       (ad_out),
      .ad_oe        (ad_oe),
      .loc_addr     (loc_addr),
      .loc_wdata    (loc_wdata),
      .loc_we       (loc_we),
      .loc_rdata    (loc_rdata),
      .bus_wr_pulse (bus_wr_pulse),
      .bus_wr_addr  (bus_wr_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish before 500000");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full strobed bus write cycle (phase 0 = address, 1 = data); stimulus only.
   task automatic bus_cycle(input logic phase, input logic [7:0] data);
      cs_n  = 1'b0;
      a_d   = phase;
      ad_in = data;
      rd_n  = 1'b1;
      tick();
      wr_n = 1'b0;
      repeat (4) tick();
      wr_n = 1'b1;
      repeat (4) tick();
      cs_n = 1'b1;
      tick();
   endtask

   // Data-phase bus write with a local write landing on the same commit edge.
   // Returns just after that edge with cs_n still low.
   task automatic bus_data_with_local(input logic [7:0] bdata, input logic [7:0] laddr,
                                      input logic [7:0] ldata);
      cs_n  = 1'b0;
      a_d   = 1'b1;
      ad_in = bdata;
      tick();
      wr_n = 1'b0;
      repeat (4) tick();
      wr_n = 1'b1;
      tick();
      tick();
      loc_addr  = laddr;
      loc_wdata = ldata;
      loc_we    = 1'b1;
      tick();
      loc_we = 1'b0;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      cs_n      = 1'b1;
      a_d       = 1'b0;
      wr_n      = 1'b1;
      rd_n      = 1'b1;
      ad_in     = 8'h00;
      loc_addr  = 8'h00;
      loc_wdata = 8'h00;
      loc_we    = 1'b0;
      repeat (3) tick();
      checks++;
      if (ad_oe !== 1'b0) begin
         errors++;
         $display("FAIL reset_oe: got %b want 0", ad_oe);
      end
      checks++;
      if (ad_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_ad_out: got %h want 00", ad_out);
      end
      checks++;
      if (bus_wr_pulse !== 1'b0 || bus_wr_addr !== 8'h00) begin
         errors++;
         $display("FAIL reset_wr: got pulse %b addr %h want 0 00", bus_wr_pulse, bus_wr_addr);
      end
      checks++;
      if (loc_rdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_reg0: got %h want 00", loc_rdata);
      end
      reset_n = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_bus_write();
      loc_addr = 8'h05;
      cs_n  = 1'b0;
      a_d   = 1'b0;
      ad_in = 8'h05;
      tick();
      wr_n = 1'b0;
      repeat (4) tick();
      wr_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (bus_wr_pulse !== 1'b0) begin
            errors++;
            $display("FAIL addr_phase_pulse k=%0d: got %b want 0", k, bus_wr_pulse);
         end
      end
      a_d   = 1'b1;
      ad_in = 8'hA7;
      tick();
      wr_n = 1'b0;
      repeat (4) tick();
      wr_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (bus_wr_pulse !== (k == 3)) begin
            errors++;
            $display("FAIL write_pulse k=%0d: got %b want %b", k, bus_wr_pulse, (k == 3));
         end
         if (k == 3) begin
            checks++;
            if (bus_wr_addr !== 8'h05) begin
               errors++;
               $display("FAIL write_addr: got %h want 05", bus_wr_addr);
            end
            checks++;
            if (loc_rdata !== 8'hA7) begin
               errors++;
               $display("FAIL write_reg5: got %h want a7", loc_rdata);
            end
         end
      end
      cs_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_bus_read();
      bus_cycle(1'b0, 8'h05);
      cs_n = 1'b0;
      a_d  = 1'b1;
      rd_n = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks++;
         if (ad_oe !== (k >= 3)) begin
            errors++;
            $display("FAIL read_oe_rise k=%0d: got %b want %b", k, ad_oe, (k >= 3));
         end
         if (k >= 3) begin
            checks++;
            if (ad_out !== 8'hA7) begin
               errors++;
               $display("FAIL read_data k=%0d: got %h want a7", k, ad_out);
            end
         end
      end
      rd_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++;
         if (ad_oe !== (k < 3)) begin
            errors++;
            $display("FAIL read_oe_fall k=%0d: got %b want %b", k, ad_oe, (k < 3));
         end
      end
      checks++;
      if (ad_out !== 8'hA7) begin
         errors++;
         $display("FAIL read_data_hold: got %h want a7", ad_out);
      end
      cs_n = 1'b1;
      a_d  = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_out_of_range();
      bus_cycle(1'b0, 8'h20);
      cs_n  = 1'b0;
      a_d   = 1'b1;
      ad_in = 8'h3C;
      tick();
      wr_n = 1'b0;
      repeat (4) tick();
      wr_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks++;
         if (bus_wr_pulse !== 1'b0) begin
            errors++;
            $display("FAIL oor_pulse k=%0d: got %b want 0", k, bus_wr_pulse);
         end
      end
      checks++;
      if (bus_wr_addr !== 8'h05) begin
         errors++;
         $display("FAIL oor_wr_addr: got %h want 05", bus_wr_addr);
      end
      loc_addr = 8'h05;
      #1;
      checks++;
      if (loc_rdata !== 8'hA7) begin
         errors++;
         $display("FAIL oor_reg5: got %h want a7", loc_rdata);
      end
      loc_addr = 8'h00;
      #1;
      checks++;
      if (loc_rdata !== 8'h00) begin
         errors++;
         $display("FAIL oor_reg0: got %h want 00", loc_rdata);
      end
      loc_addr = 8'h20;
      #1;
      checks++;
      if (loc_rdata !== 8'h00) begin
         errors++;
         $display("FAIL oor_loc_read: got %h want 00", loc_rdata);
      end
      rd_n = 1'b0;
      repeat (3) tick();
      checks++;
      if (ad_oe !== 1'b1 || ad_out !== 8'h00) begin
         errors++;
         $display("FAIL oor_read: got oe %b data %h want 1 00", ad_oe, ad_out);
      end
      rd_n = 1'b1;
      cs_n = 1'b1;
      repeat (4) tick();
      checks++;
      if (ad_oe !== 1'b0) begin
         errors++;
         $display("FAIL oor_read_end: got %b want 0", ad_oe);
      end
      // Local write to 0x13 must not alias onto reg 3.
      loc_addr  = 8'h13;
      loc_wdata = 8'h99;
      loc_we    = 1'b1;
      tick();
      loc_we   = 1'b0;
      loc_addr = 8'h03;
      #1;
      checks++;
      if (loc_rdata !== 8'h00) begin
         errors++;
         $display("FAIL oor_loc_write: got %h want 00", loc_rdata);
      end
      a_d = 1'b0;
      tick();
   endtask

   task automatic test_collision();
      bus_cycle(1'b0, 8'h03);
      bus_data_with_local(8'h11, 8'h03, 8'h22);
      checks++;
      if (bus_wr_pulse !== 1'b1) begin
         errors++;
         $display("FAIL coll_pulse: got %b want 1", bus_wr_pulse);
      end
      checks++;
      if (loc_rdata !== 8'h11) begin
         errors++;
         $display("FAIL coll_same_reg: got %h want 11", loc_rdata);
      end
      cs_n = 1'b1;
      tick();
      bus_cycle(1'b0, 8'h04);
      bus_data_with_local(8'h44, 8'h06, 8'h66);
      cs_n = 1'b1;
      tick();
      loc_addr = 8'h04;
      #1;
      checks++;
      if (loc_rdata !== 8'h44) begin
         errors++;
         $display("FAIL coll_diff_bus: got %h want 44", loc_rdata);
      end
      loc_addr = 8'h06;
      #1;
      checks++;
      if (loc_rdata !== 8'h66) begin
         errors++;
         $display("FAIL coll_diff_loc: got %h want 66", loc_rdata);
      end
      // Local write to the register being read must not disturb the read.
      bus_cycle(1'b0, 8'h03);
      cs_n = 1'b0;
      a_d  = 1'b1;
      rd_n = 1'b0;
      repeat (3) tick();
      checks++;
      if (ad_oe !== 1'b1 || ad_out !== 8'h11) begin
         errors++;
         $display("FAIL inflight_start: got oe %b data %h want 1 11", ad_oe, ad_out);
      end
      loc_addr  = 8'h03;
      loc_wdata = 8'h55;
      loc_we    = 1'b1;
      tick();
      loc_we = 1'b0;
      tick();
      checks++;
      if (loc_rdata !== 8'h55) begin
         errors++;
         $display("FAIL inflight_reg: got %h want 55", loc_rdata);
      end
      checks++;
      if (ad_oe !== 1'b1 || ad_out !== 8'h11) begin
         errors++;
         $display("FAIL inflight_hold: got oe %b data %h want 1 11", ad_oe, ad_out);
      end
      rd_n = 1'b1;
      cs_n = 1'b1;
      a_d  = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_abort_error();
      bus_cycle(1'b0, 8'h05);
      cs_n = 1'b0;
      a_d  = 1'b1;
      rd_n = 1'b0;
      repeat (3) tick();
      checks++;
      if (ad_oe !== 1'b1) begin
         errors++;
         $display("FAIL abort_start: got %b want 1", ad_oe);
      end
      cs_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++;
         if (ad_oe !== (k < 3)) begin
            errors++;
            $display("FAIL abort_oe k=%0d: got %b want %b", k, ad_oe, (k < 3));
         end
      end
      rd_n = 1'b1;
      a_d  = 1'b0;
      repeat (3) tick();
      // rd_n and wr_n low together: bus error.
      cs_n  = 1'b0;
      a_d   = 1'b1;
      rd_n  = 1'b0;
      wr_n  = 1'b0;
      ad_in = 8'hEE;
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks++;
         if (ad_oe !== 1'b0) begin
            errors++;
            $display("FAIL error_oe k=%0d: got %b want 0", k, ad_oe);
         end
      end
      rd_n = 1'b1;
      wr_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++;
         if (bus_wr_pulse !== 1'b0 || ad_oe !== 1'b0) begin
            errors++;
            $display("FAIL error_release k=%0d: got pulse %b oe %b want 0 0", k, bus_wr_pulse, ad_oe);
         end
      end
      loc_addr = 8'h05;
      #1;
      checks++;
      if (loc_rdata !== 8'hA7) begin
         errors++;
         $display("FAIL error_reg5: got %h want a7", loc_rdata);
      end
      cs_n = 1'b1;
      a_d  = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset_mid_read();
      bus_cycle(1'b0, 8'h05);
      cs_n = 1'b0;
      a_d  = 1'b1;
      rd_n = 1'b0;
      repeat (3) tick();
      checks++;
      if (ad_oe !== 1'b1) begin
         errors++;
         $display("FAIL midreset_start: got %b want 1", ad_oe);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (ad_oe !== 1'b0 || ad_out !== 8'h00) begin
         errors++;
         $display("FAIL midreset_oe: got oe %b data %h want 0 00", ad_oe, ad_out);
      end
      cs_n = 1'b1;
      a_d  = 1'b0;
      rd_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         loc_addr = 8'(i);
         #1;
         checks++;
         if (loc_rdata !== 8'h00) begin
            errors++;
            $display("FAIL midreset_reg%0d: got %h want 00", i, loc_rdata);
         end
      end
      tick();
      reset_n = 1'b1;
      repeat (3) tick();
      checks++;
      if (ad_oe !== 1'b0 || bus_wr_addr !== 8'h00) begin
         errors++;
         $display("FAIL postreset: got oe %b wr_addr %h want 0 00", ad_oe, bus_wr_addr);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_bus_write();
      test_bus_read();
      test_out_of_range();
      test_collision();
      test_abort_error();
      test_reset_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
